// File: rtl/dma_dispatch_pkg.sv
// Shared definitions for the DMA dispatch controller: DMA word field layout,
// the dispatch FSM state encoding and the packed DMA word type.
package dma_dispatch_pkg;

  localparam int PAYLOAD_MSB = 31;
  localparam int PAYLOAD_LSB = 8;
  localparam int EN_BIT      = 7;
  localparam int SEL_MSB     = 2;
  localparam int SEL_LSB     = 0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef struct packed {
    logic [PAYLOAD_MSB:PAYLOAD_LSB] payload;
    logic                           en;
    logic [EN_BIT-1:SEL_MSB+1]      rsvd;
    logic [SEL_MSB:SEL_LSB]         sel;
  } dma_word_t;

endpackage

// File: rtl/dma_dispatch_ctrl_if.sv
// DMA input stream and per-lane output handshake bundle of dma_dispatch_ctrl.
interface dma_dispatch_ctrl_if #(
  parameter int NUM_LANES = 6,
  parameter int DATA_W    = 24
);
  import dma_dispatch_pkg::*;

  dma_word_t                   dma_word;
  logic                        dma_valid;
  logic                        dma_ready;
  logic [NUM_LANES*DATA_W-1:0] lane_data;
  logic [NUM_LANES-1:0]        lane_valid;
  logic [NUM_LANES-1:0]        lane_ready;

  modport master (
    output dma_word, dma_valid, lane_ready,
    input  dma_ready, lane_data, lane_valid
  );

  modport slave (
    input  dma_word, dma_valid, lane_ready,
    output dma_ready, lane_data, lane_valid
  );

endinterface

// File: rtl/dma_word_fifo.sv
// Synchronous word FIFO (power-of-two depth) with occupancy count and
// asynchronous active-high reset of the control state.
module dma_word_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/dma_dispatch_ctrl.sv
// Buffers DMA words and delivers each payload to one of NUM_LANES lanes, one
// word in flight at a time. Optional stall timeout: `define DISPATCH_TIMEOUT_EN.
module dma_dispatch_ctrl
  import dma_dispatch_pkg::*;
#(
  parameter int NUM_LANES   = 6,
  parameter int FIFO_DEPTH  = 4,
  parameter int DATA_W      = 24,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  dma_dispatch_ctrl_if.slave bus,
  output logic [7:0]         drop_count,
  output logic               bad_sel,
  output logic               timeout,
  output logic               busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                      r_state, w_state_nxt;
  dma_word_t                   w_head;
  logic                        w_push, w_pop, w_full, w_empty;
  logic [CNT_W-1:0]            w_cnt;
  logic [NUM_LANES-1:0]        r_lane_valid, w_lane_valid_nxt;
  logic [NUM_LANES*DATA_W-1:0] r_lane_data, w_lane_data_nxt;
  logic [7:0]                  r_drop;
  logic                        r_bad;
  logic                        w_drop_inc, w_bad_set, w_hs, w_sel_ok, w_expire;
  logic                        w_unused_rsvd;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A pop in the same cycle never frees a slot for a push into a full FIFO.
  assign bus.dma_ready = !w_full && !rst;
  assign w_push        = bus.dma_valid && bus.dma_ready;

  dma_word_fifo #(
    .WIDTH ($bits(dma_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_wdata (bus.dma_word),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  assign w_unused_rsvd = ^w_head.rsvd;
  assign w_sel_ok      = int'(w_head.sel) < NUM_LANES;
  assign w_hs          = |(r_lane_valid & bus.lane_ready);

`ifdef DISPATCH_TIMEOUT_EN
  logic [7:0] r_stall;
  logic       r_timeout;

  assign w_expire = (r_state == WAIT) && !w_hs && (r_stall == 8'(TIMEOUT_CYC - 1));
  assign timeout  = r_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == ISSUE)                r_stall <= '0;
      else if (r_state == WAIT && !w_hs)   r_stall <= r_stall + 8'd1;
      if (w_expire)                        r_timeout <= 1'b1;
    end
  end
`else
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_pop            = 1'b0;
    w_lane_valid_nxt = r_lane_valid;
    w_lane_data_nxt  = r_lane_data;
    w_drop_inc       = 1'b0;
    w_bad_set        = 1'b0;
    unique case (r_state)
      IDLE: if (!w_empty) w_state_nxt = ISSUE;
      // ISSUE is only ever entered with at least one word buffered.
      ISSUE: begin
        w_pop = 1'b1;
        if (w_head.en && w_sel_ok) begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (int'(w_head.sel) == i) begin
              w_lane_valid_nxt[i]                  = 1'b1;
              w_lane_data_nxt[i*DATA_W +: DATA_W]  = DATA_W'(w_head.payload);
            end
          end
          w_state_nxt = WAIT;
        end else begin
          w_drop_inc  = 1'b1;
          w_bad_set   = w_head.en;
          w_state_nxt = (w_cnt > CNT_W'(1)) ? ISSUE : IDLE;
        end
      end
      WAIT: begin
        if (w_hs || w_expire) begin
          w_lane_valid_nxt = '0;
          w_drop_inc       = w_expire;
          w_state_nxt      = w_empty ? IDLE : ISSUE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lane_valid <= '0;
      r_lane_data  <= '0;
      r_drop       <= '0;
      r_bad        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lane_valid <= w_lane_valid_nxt;
      r_lane_data  <= w_lane_data_nxt;
      if (w_drop_inc) r_drop <= sat_inc8(r_drop);
      if (w_bad_set)  r_bad  <= 1'b1;
    end
  end

  assign bus.lane_valid = r_lane_valid;
  assign bus.lane_data  = r_lane_data;
  assign drop_count     = r_drop;
  assign bad_sel        = r_bad;
  assign busy           = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_dma_dispatch_ctrl.sv
// Bench for dma_dispatch_ctrl: directed latency/drop/backpressure/reset cases
// plus random traffic scored against an order-preserving delivery model.
module tb_dma_dispatch_ctrl;
  import dma_dispatch_pkg::*;

  localparam int NL = 6;
  localparam int DW = 24;
  localparam int NW = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] drop_count;
  logic       bad_sel, timeout, busy;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] q_got[$];
  int          n_vseen = 0;

  dma_dispatch_ctrl_if #(.NUM_LANES(NL), .DATA_W(DW)) bus ();

  dma_dispatch_ctrl #(
    .NUM_LANES   (NL),
    .FIFO_DEPTH  (4),
    .DATA_W      (DW),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .drop_count (drop_count),
    .bad_sel    (bad_sel),
    .timeout    (timeout),
    .busy       (busy)
  );

  initial forever #5 clk = ~clk;

  // Handshake monitor: inputs settle after posedge, so a valid&ready seen at
  // negedge completes on the following posedge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.lane_valid != '0) n_vseen++;
      for (int i = 0; i < NL; i++)
        if (bus.lane_valid[i] && bus.lane_ready[i])
          q_got.push_back({8'(i), bus.lane_data[i*DW +: DW]});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkw(input logic [23:0] p, input logic en, input logic [2:0] sel);
    return {p, en, 4'b0000, sel};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.dma_valid  = 1'b0;
    bus.dma_word   = '0;
    bus.lane_ready = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic push(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    bus.dma_word  = w;
    bus.dma_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.dma_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.dma_valid = 1'b0;
    chk("push_accepted", 32'(ok), 32'd1);
  endtask

  initial begin
    int          base, vbase, n, idx, exp_drop;
    bit          acc, exp_bad;
    logic [31:0] cur;
    logic [31:0] exp_q[$];

    // Reset values
    bus.dma_valid  = 1'b0;
    bus.dma_word   = '0;
    bus.lane_ready = '0;
    tick(3);
    chk("rst_dma_ready", 32'(bus.dma_ready), 32'd0);
    chk("rst_lane_valid", 32'(bus.lane_valid), 32'd0);
    chk("rst_lane_data0", 32'(bus.lane_data[0 +: DW]), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_bad_sel", 32'(bad_sel), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_dma_ready", 32'(bus.dma_ready), 32'd1);

    // Latency: accepted at edge N, valid after N+2, handshake at N+3
    bus.lane_ready = '1;
    base = q_got.size();
    bus.dma_word  = mkw(24'hABCDEF, 1'b1, 3'd3);
    bus.dma_valid = 1'b1;
    tick(1);
    bus.dma_valid = 1'b0;
    chk("lat_n0_valid", 32'(bus.lane_valid), 32'd0);
    chk("lat_n0_busy", 32'(busy), 32'd1);
    tick(1);
    chk("lat_n1_valid", 32'(bus.lane_valid), 32'd0);
    tick(1);
    chk("lat_n2_valid", 32'(bus.lane_valid), 32'b001000);
    chk("lat_n2_data", 32'(bus.lane_data[3*DW +: DW]), 32'hABCDEF);
    tick(1);
    chk("lat_n3_valid", 32'(bus.lane_valid), 32'd0);
    chk("lat_n3_count", 32'(q_got.size() - base), 32'd1);
    if (q_got.size() > base) chk("lat_n3_word", q_got[base], {8'd3, 24'hABCDEF});
    chk("lat_n3_data_held", 32'(bus.lane_data[3*DW +: DW]), 32'hABCDEF);
    chk("lat_n3_busy", 32'(busy), 32'd0);

    // Disabled word is discarded silently
    do_reset();
    bus.lane_ready = '1;
    vbase = n_vseen;
    push(mkw(24'h123456, 1'b0, 3'd1));
    tick(5);
    chk("dis_drop", 32'(drop_count), 32'd1);
    chk("dis_bad_sel", 32'(bad_sel), 32'd0);
    chk("dis_no_valid", 32'(n_vseen - vbase), 32'd0);

    // Enabled words with nonexistent lanes
    do_reset();
    bus.lane_ready = '1;
    vbase = n_vseen;
    push(mkw(24'h00AA55, 1'b1, 3'd6));
    push(mkw(24'h0055AA, 1'b1, 3'd7));
    tick(4);
    chk("badsel_drop", 32'(drop_count), 32'd2);
    chk("badsel_flag", 32'(bad_sel), 32'd1);
    chk("badsel_no_valid", 32'(n_vseen - vbase), 32'd0);

    // Backpressure: 4 buffered + 1 in flight, then drain in order at 1 word / 2 cycles
    do_reset();
    base = q_got.size();
    for (int i = 0; i < 5; i++) push(mkw(24'h000100 + 24'(i), 1'b1, 3'd0));
    tick(3);
    chk("bp_dma_ready", 32'(bus.dma_ready), 32'd0);
    chk("bp_lane_valid", 32'(bus.lane_valid), 32'd1);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_head_data", 32'(bus.lane_data[0 +: DW]), 32'h100);
    bus.lane_ready = 6'b000001;
    tick(10);
    chk("bp_count", 32'(q_got.size() - base), 32'd5);
    for (int i = 0; i < 5; i++)
      if (q_got.size() > base + i) chk("bp_order", q_got[base+i], {8'd0, 24'h000100 + 24'(i)});
    chk("bp_idle", 32'(busy), 32'd0);

    // Stall on lane 2 with ready held low
    do_reset();
    push(mkw(24'h222222, 1'b1, 3'd2));
    for (int k = 0; k < 10 && bus.lane_valid == '0; k++) tick(1);
    n = 0;
    while (bus.lane_valid != '0 && n < 400) begin
      n++;
      tick(1);
    end
`ifdef DISPATCH_TIMEOUT_EN
    chk("to_cycles", 32'(n), 32'd255);
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_drop", 32'(drop_count), 32'd1);
    chk("to_valid", 32'(bus.lane_valid), 32'd0);
`else
    chk("stall_cycles", 32'(n), 32'd400);
    chk("stall_timeout", 32'(timeout), 32'd0);
    chk("stall_drop", 32'(drop_count), 32'd0);
    chk("stall_valid", 32'(bus.lane_valid), 32'b000100);
`endif

    // Reset during WAIT with three words queued
    do_reset();
    for (int i = 0; i < 4; i++) push(mkw(24'h330000 + 24'(i), 1'b1, 3'd1));
    tick(2);
    chk("rw_pre_valid", 32'(bus.lane_valid), 32'b000010);
    chk("rw_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_valid", 32'(bus.lane_valid), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_drop", 32'(drop_count), 32'd0);
    chk("rw_dma_ready", 32'(bus.dma_ready), 32'd0);
    tick(2);
    rst = 1'b0;
    base  = q_got.size();
    vbase = n_vseen;
    bus.lane_ready = '1;
    tick(10);
    chk("rw_no_delivery", 32'(q_got.size() - base), 32'd0);
    chk("rw_no_valid", 32'(n_vseen - vbase), 32'd0);
    chk("rw_idle", 32'(busy), 32'd0);

    // drop_count saturates at 255
    do_reset();
    for (int i = 0; i < 260; i++) push(mkw(24'(i), 1'b0, 3'(i)));
    tick(3);
    chk("sat_drop", 32'(drop_count), 32'd255);

    // Random traffic against the delivery model
    do_reset();
    base     = q_got.size();
    exp_drop = 0;
    exp_bad  = 1'b0;
    idx      = 0;
    cur      = mkw(24'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
    for (int cyc = 0; cyc < 20000 && idx < NW; cyc++) begin
      bus.lane_ready = 6'($urandom);
      bus.dma_valid  = ($urandom_range(0, 3) != 0);
      bus.dma_word   = cur;
      @(negedge clk);
      acc = bus.dma_valid && bus.dma_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        if (cur[7] && int'(cur[2:0]) < NL) exp_q.push_back({8'(cur[2:0]), cur[31:8]});
        else begin
          if (exp_drop < 255) exp_drop++;
          if (cur[7]) exp_bad = 1'b1;
        end
        idx++;
        cur = mkw(24'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
      end
    end
    bus.dma_valid  = 1'b0;
    bus.lane_ready = '1;
    chk("rand_all_pushed", 32'(idx), 32'(NW));
    for (int k = 0; k < 200 && busy; k++) tick(1);
    tick(1);
    chk("rand_drained", 32'(busy), 32'd0);
    chk("rand_count", 32'(q_got.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (q_got.size() > base + i) chk("rand_word", q_got[base+i], exp_q[i]);
    chk("rand_drop", 32'(drop_count), 32'(exp_drop));
    chk("rand_bad_sel", 32'(bad_sel), 32'(exp_bad));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
